// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode renderer.
package text_pkg;

    localparam logic [7:0]  CHAR_SPACE = 8'd32;
    localparam int unsigned GLYPH_W    = 5;
    localparam int unsigned CELL_W     = 8;
    localparam int unsigned CELL_H     = 8;
    localparam int unsigned RENDER_LAT = 3;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

endpackage

// File: rtl/text_render_ctrl_if.sv
// Host-side bus of the text renderer: buffer writes, clear request and cursor control.
interface text_render_ctrl_if #(
    parameter int unsigned ADDR_W = 9
) ();

    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [7:0]        wr_data_i;
    logic              wr_ready_o;
    logic              clear_i;
    logic              busy_o;
    logic              cursor_en_i;
    logic [ADDR_W-1:0] cursor_addr_i;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, clear_i, cursor_en_i, cursor_addr_i,
        input  wr_ready_o, busy_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, clear_i, cursor_en_i, cursor_addr_i,
        output wr_ready_o, busy_o
    );

endinterface

// File: rtl/text_buffer_ram.sv
// Character buffer: one write port, one synchronous read-first read port.
module text_buffer_ram
    import text_pkg::*;
#(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Write port; no reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port; a same-cycle write is not visible yet (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= CHAR_SPACE;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/text_render_ctrl.sv
// Text-mode scheduler: maps each VGA pixel onto a buffer cell, drives the glyph ROM lookup and
// returns one registered text pixel, 3 cycles behind hcount/vcount, with matching delayed syncs.
module text_render_ctrl
    import text_pkg::*;
#(
    parameter int unsigned COLS         = 32,
    parameter int unsigned ROWS         = 16,
    parameter int unsigned X0           = 0,
    parameter int unsigned Y0           = 0,
    parameter int unsigned SCALE_LOG2   = 1,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [10:0]         hcount,
    input  logic [10:0]         vcount,
    input  logic                video_on_i,
    input  logic                hsync_i,
    input  logic                vsync_i,
    text_render_ctrl_if.slave   host,
    output logic [7:0]          glyph_sel_o,
    output logic [2:0]          glyph_x_o,
    output logic [2:0]          glyph_y_o,
    input  logic                glyph_pixel_i,
    output logic                pixel_o,
    output logic                video_on_o,
    output logic                hsync_o,
    output logic                vsync_o
);

    localparam int unsigned DEPTH   = COLS * ROWS;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // ---------------- geometry ----------------
    logic [10:0]       w_px, w_py, w_col, w_row;
    logic              w_in_win, w_cursor_hit;
    logic [ADDR_W-1:0] w_addr;

    assign w_px     = (hcount - 11'(X0)) >> SCALE_LOG2;
    assign w_py     = (vcount - 11'(Y0)) >> SCALE_LOG2;
    assign w_col    = w_px >> $clog2(CELL_W);
    assign w_row    = w_py >> $clog2(CELL_H);
    assign w_in_win = (hcount >= 11'(X0)) && (vcount >= 11'(Y0)) &&
                      (w_col < 11'(COLS)) && (w_row < 11'(ROWS));
    assign w_addr   = ADDR_W'(w_row * COLS + w_col);
    assign w_cursor_hit = host.cursor_en_i && (w_addr == host.cursor_addr_i);

    // ---------------- blink ----------------
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_blink_ph;
    logic               w_tick, w_wrap, w_blink_now;

    assign w_tick = (hcount == 11'd0) && (vcount == 11'd0);
    assign w_wrap = w_tick && (r_frame_cnt == FRAME_W'(BLINK_FRAMES - 1));
    // Phase as seen by the pixel entering S1 now, so a frame's first pixel already uses its phase.
    assign w_blink_now = w_wrap ? ~r_blink_ph : r_blink_ph;

    // Frame counter and cursor blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_blink_ph  <= 1'b1;
        end else if (w_tick) begin
            r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + 1'b1;
            r_blink_ph  <= w_blink_now;
        end
    end

    // ---------------- clear FSM ----------------
    clr_state_t        r_state, w_state_next;
    logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_next;
    logic              w_busy, w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [7:0]        w_wdata;

    // State register; reset lands in CLEAR so the buffer starts blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    // Next state, clear sweep and RAM write-port arbitration.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_we            = 1'b0;
        w_waddr         = host.wr_addr_i;
        w_wdata         = host.wr_data_i;
        unique case (r_state)
            IDLE: begin
                w_we = host.wr_en_i &&
                       ({1'b0, host.wr_addr_i} < (ADDR_W + 1)'(DEPTH));
                if (host.clear_i) begin
                    w_state_next    = CLEAR;
                    w_clr_addr_next = '0;
                end
            end
            CLEAR: begin
                w_we            = 1'b1;
                w_waddr         = r_clr_addr;
                w_wdata         = CHAR_SPACE;
                w_clr_addr_next = r_clr_addr + 1'b1;
                if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
                    w_state_next    = IDLE;
                    w_clr_addr_next = '0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_busy          = (r_state == CLEAR);
    assign host.busy_o     = w_busy;
    assign host.wr_ready_o = (r_state == IDLE);

    // ---------------- render pipeline ----------------
    logic [ADDR_W-1:0]     r_s1_addr;
    logic [2:0]            r_s1_gx, r_s1_gy;
    logic                  r_s1_in_win, r_s1_cur;
    logic                  r_s2_gx_ok, r_s2_in_win, r_s2_cur;
    logic [2:0]            r_glyph_x, r_glyph_y;
    logic                  r_pixel;
    logic [RENDER_LAT-1:0] r_von, r_hs, r_vs;

    text_buffer_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_s1_addr),
        .o_rdata (glyph_sel_o)
    );

    // S1 address/coords, S2 glyph lookup, S3 pixel; syncs ride a matching delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_addr   <= '0;
            r_s1_gx     <= '0;
            r_s1_gy     <= '0;
            r_s1_in_win <= 1'b0;
            r_s1_cur    <= 1'b0;
            r_s2_gx_ok  <= 1'b0;
            r_s2_in_win <= 1'b0;
            r_s2_cur    <= 1'b0;
            r_glyph_x   <= '0;
            r_glyph_y   <= '0;
            r_pixel     <= 1'b0;
            r_von       <= '0;
            r_hs        <= '0;
            r_vs        <= '0;
        end else begin
            r_s1_addr   <= w_addr;
            r_s1_gx     <= w_px[2:0];
            r_s1_gy     <= w_py[2:0];
            r_s1_in_win <= w_in_win;
            r_s1_cur    <= w_cursor_hit && w_blink_now;
            r_s2_gx_ok  <= r_s1_gx < 3'(GLYPH_W);
            r_s2_in_win <= r_s1_in_win;
            r_s2_cur    <= r_s1_cur;
            r_glyph_x   <= (r_s1_gx < 3'(GLYPH_W)) ? r_s1_gx : 3'd0;
            r_glyph_y   <= r_s1_gy;
            // Cursor inverts the whole cell; gap columns never show ROM data.
            r_pixel     <= r_s2_in_win && r_von[RENDER_LAT-2] && !w_busy &&
                           ((r_s2_gx_ok && glyph_pixel_i) ^ r_s2_cur);
            r_von       <= {r_von[RENDER_LAT-2:0], video_on_i};
            r_hs        <= {r_hs[RENDER_LAT-2:0], hsync_i};
            r_vs        <= {r_vs[RENDER_LAT-2:0], vsync_i};
        end
    end

    assign glyph_x_o  = r_glyph_x;
    assign glyph_y_o  = r_glyph_y;
    assign pixel_o    = r_pixel;
    assign video_on_o = r_von[RENDER_LAT-1];
    assign hsync_o    = r_hs[RENDER_LAT-1];
    assign vsync_o    = r_vs[RENDER_LAT-1];

endmodule

// File: tb/tb_text_render_ctrl.sv
// Directed bench for text_render_ctrl with a small 5x8 glyph ROM holding 'L' and 'H'.
module tb_text_render_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = 11'd1000;
    logic [10:0] vcount = 11'd1000;
    logic        video_on_i = 1'b0;
    logic        hsync_i = 1'b0;
    logic        vsync_i = 1'b0;
    logic [7:0]  glyph_sel;
    logic [2:0]  glyph_x, glyph_y;
    logic        glyph_pixel;
    logic        pixel_o, video_on_o, hsync_o, vsync_o;

    int errors = 0;
    int checks = 0;
    int cnt;

    typedef struct {
        logic       pix;
        logic [2:0] sync;
        logic       chk_sel;
        logic [7:0] sel;
        logic [2:0] gx;
        logic [2:0] gy;
        string      tag;
    } exp_t;

    exp_t pq[$];

    text_render_ctrl_if #(.ADDR_W(9)) hif ();

    text_render_ctrl #(
        .COLS         (32),
        .ROWS         (16),
        .X0           (0),
        .Y0           (0),
        .SCALE_LOG2   (0),
        .BLINK_FRAMES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hcount        (hcount),
        .vcount        (vcount),
        .video_on_i    (video_on_i),
        .hsync_i       (hsync_i),
        .vsync_i       (vsync_i),
        .host          (hif),
        .glyph_sel_o   (glyph_sel),
        .glyph_x_o     (glyph_x),
        .glyph_y_o     (glyph_y),
        .glyph_pixel_i (glyph_pixel),
        .pixel_o       (pixel_o),
        .video_on_o    (video_on_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o)
    );

    always #5 clk = ~clk;

    // 5x8 ROM, x=0 is the leftmost dot, y=0 the top row.
    function automatic logic rom(input logic [7:0] sel, input logic [2:0] x, input logic [2:0] y);
        logic [4:0] line;
        line = 5'b00000;
        case (sel)
            8'd76: line = (y == 3'd6) ? 5'b11111 : ((y < 3'd6) ? 5'b10000 : 5'b00000);
            8'd72: line = (y == 3'd3) ? 5'b11111 : ((y < 3'd7) ? 5'b10001 : 5'b00000);
            default: line = 5'b00000;
        endcase
        if (x > 3'd4) return 1'b0;
        return line[3'd4 - x];
    endfunction

    assign glyph_pixel = rom(glyph_sel, glyph_x, glyph_y);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One pixel clock: check outputs owed by earlier inputs, then drive new inputs.
    task automatic step(input logic [10:0] h, input logic [10:0] v, input logic von,
                        input logic hs, input logic vs, input logic ep, input logic cs,
                        input logic [7:0] es, input logic [2:0] ex, input logic [2:0] ey,
                        input string tag);
        exp_t e;
        @(negedge clk);
        if (pq.size() >= 2 && pq[pq.size()-2].chk_sel) begin
            e = pq[pq.size()-2];
            check({e.tag, "_sel"}, {18'd0, glyph_sel, glyph_x, glyph_y}, {18'd0, e.sel, e.gx, e.gy});
        end
        if (pq.size() == 3) begin
            e = pq.pop_front();
            check({e.tag, "_pix"}, {31'd0, pixel_o}, {31'd0, e.pix});
            check({e.tag, "_sync"}, {29'd0, video_on_o, hsync_o, vsync_o}, {29'd0, e.sync});
        end
        hcount = h; vcount = v; video_on_i = von; hsync_i = hs; vsync_i = vs;
        e.pix = ep; e.sync = {von, hs, vs}; e.chk_sel = cs;
        e.sel = es; e.gx = ex; e.gy = ey; e.tag = tag;
        pq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(11'd1000, 11'd1000, 0, 0, 0, 0, 0, 8'd0, 3'd0, 3'd0, "idle");
    endtask

    task automatic host_write(input logic [8:0] a, input logic [7:0] d);
        hif.wr_en_i = 1'b1; hif.wr_addr_i = a; hif.wr_data_i = d;
        idle(1);
        hif.wr_en_i = 1'b0;
    endtask

    // Scan dot (0,1) of a cell and expect the given code there with a dark pixel.
    task automatic probe_cell(input int a, input logic [7:0] code, input string tag);
        step(11'((a % 32) * 8), 11'((a / 32) * 8 + 1), 1, 0, 0, 0, 1, code, 3'd0, 3'd1, tag);
    endtask

    task automatic wait_clear(input string tag);
        cnt = 0;
        while (hif.busy_o === 1'b1 && cnt < 2000) begin
            cnt++;
            idle(1);
        end
        check({tag, "_busy_cycles"}, cnt, 512);
        check({tag, "_ready"}, {30'd0, hif.wr_ready_o, hif.busy_o}, 32'd2);
    endtask

    initial begin
        hif.wr_en_i = 1'b0; hif.wr_addr_i = '0; hif.wr_data_i = '0;
        hif.clear_i = 1'b0; hif.cursor_en_i = 1'b0; hif.cursor_addr_i = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_outs", {28'd0, pixel_o, video_on_o, hsync_o, vsync_o}, 32'd0);
        check("rst_glyph", {18'd0, glyph_sel, glyph_x, glyph_y}, {18'd0, 8'd32, 3'd0, 3'd0});
        check("rst_busy", {30'd0, hif.wr_ready_o, hif.busy_o}, 32'd1);

        // 1: initial clear, then whole buffer reads spaces with dark pixels
        rst_n = 1'b1;
        wait_clear("init");
        for (int a = 0; a < 512; a++) probe_cell(a, 8'd32, "blank");
        idle(3);

        // 2: 'L' at cell 0, dot row 6; syncs ride along
        host_write(9'd0, 8'd76);
        for (int h = 0; h < 8; h++)
            step(11'(h), 11'd6, 1, h[0], h[1], (h < 5), 1, 8'd76,
                 (h < 5) ? 3'(h) : 3'd0, 3'd6, "L_row6");
        idle(3);

        // 3: 'H' at cell 33, dot row 3
        host_write(9'd33, 8'd72);
        for (int h = 8; h < 16; h++)
            step(11'(h), 11'd11, 1, 0, 1, (h < 13), 1, 8'd72,
                 (h < 13) ? 3'(h - 8) : 3'd0, 3'd3, "H_row3");
        idle(3);

        // 5: write+clear together, clear re-request and write during CLEAR
        hif.clear_i = 1'b1; hif.wr_en_i = 1'b1; hif.wr_addr_i = 9'd5; hif.wr_data_i = 8'd65;
        idle(1);
        hif.clear_i = 1'b0; hif.wr_en_i = 1'b0;
        cnt = 0;
        while (hif.busy_o === 1'b1 && cnt < 2000) begin
            cnt++;
            if (cnt == 100) hif.clear_i = 1'b1;
            if (cnt == 300) begin
                check("clr_not_ready", {31'd0, hif.wr_ready_o}, 32'd0);
                hif.wr_en_i = 1'b1; hif.wr_addr_i = 9'd1; hif.wr_data_i = 8'd72;
            end
            if (cnt == 1) probe_cell(5, 8'd65, "wr_before_clr");
            else idle(1);
            hif.clear_i = 1'b0; hif.wr_en_i = 1'b0;
        end
        check("clr2_busy_cycles", cnt, 512);
        check("clr2_ready", {30'd0, hif.wr_ready_o, hif.busy_o}, 32'd2);
        probe_cell(0, 8'd32, "cleared0");
        probe_cell(1, 8'd32, "dropped_wr");
        probe_cell(5, 8'd32, "cleared5");
        probe_cell(33, 8'd32, "cleared33");
        idle(3);

        // 4: cursor on blank cell 0; frame 0 is the partial frame before the first tick
        hif.cursor_en_i = 1'b1; hif.cursor_addr_i = 9'd0;
        for (int f = 0; f < 4; f++)
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    if (!(f == 0 && x == 0 && y == 0))
                        step(11'(x), 11'(y), 1, 0, 0, (f < 2), 0, 8'd0, 3'd0, 3'd0,
                             $sformatf("cursor_f%0d", f));
        idle(3);
        hif.cursor_en_i = 1'b0;

        // 6: reset in the middle of a clear
        host_write(9'd511, 8'd76);
        hif.clear_i = 1'b1;
        idle(1);
        hif.clear_i = 1'b0;
        for (int i = 0; i < 200; i++)
            step(11'd249, 11'd121, 1, 1, 1, 0, 1, 8'd76, 3'd1, 3'd1, "pre_rst");
        #2;
        check("pre_rst_sync", {29'd0, video_on_o, hsync_o, vsync_o}, 32'd7);
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", {28'd0, pixel_o, video_on_o, hsync_o, vsync_o}, 32'd0);
        check("async_rst_glyph", {18'd0, glyph_sel, glyph_x, glyph_y}, {18'd0, 8'd32, 3'd0, 3'd0});
        check("async_rst_busy", {31'd0, hif.busy_o}, 32'd1);
        pq.delete();
        hcount = 11'd1000; vcount = 11'd1000; video_on_i = 0; hsync_i = 0; vsync_i = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("restart");
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
